// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer wrapping a word-addressed memory array.
//
// Purpose: serves reads and writes from a DEPTH x DATA_WIDTH array at
// BASE_ADDR. It can insert a fixed number of wait states, honours PSTRB byte
// lanes on writes, and raises PSLVERR for out-of-range, misaligned or
// (optionally) non-secure accesses.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   write byte enables
//   PPROT    in   protection attributes (bit 1 = non-secure)
//   PRDATA   out  read data, non-zero only on a completing good read
//   PREADY   out  transfer completion
//   PSLVERR  out  transfer error, qualified by PREADY
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_WIDTH + 1;
  // One extra bit so the span compare is exact even when the window fills
  // the whole address space.
  localparam logic [ADDR_WIDTH:0]   SPAN       = AW1'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    setup, complete;

  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [BYTES-1:0]        pstrb_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Address decode of the live bus; only sampled on a SETUP edge, so the
  // captured copies are what the rest of the transfer actually uses.
  // Addresses below BASE_ADDR wrap to huge offsets and fail the span check.
  logic [ADDR_WIDTH-1:0]   offset_in;
  logic [IDX_W-1:0]        idx_in;
  logic                    err_in;

  assign offset_in = PADDR - BASE_ADDR;
  assign idx_in    = offset_in[LSB +: IDX_W];
  assign err_in    = ({1'b0, offset_in} >= SPAN)
                  || ((PADDR & ALIGN_MASK) != '0)
                  || ((SECURE_ONLY != 0) && PPROT[1]);

  // Only PPROT[1] has meaning here.
  logic unused_prot;
  assign unused_prot = PPROT[2] ^ PPROT[0];

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    setup      = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // PSEL with PENABLE already high and no SETUP seen is ignored.
        if (PSEL && !PENABLE) begin
          setup      = 1'b1;
          state_next = S_ACCESS;
          count_next = 4'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_next = S_IDLE;                  // abort, nothing committed
        end else if (!PENABLE) begin
          setup      = 1'b1;                    // restart, drop old request
          count_next = 4'(WAIT_STATES);
        end else if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (setup) begin
        pwrite_q <= PWRITE;
        pwdata_q <= PWDATA;
        pstrb_q  <= PSTRB;
        idx_q    <= idx_in;
        err_q    <= err_in;
      end
    end
  end

  // Memory: unreset array, byte-lane writes, registered read taken at SETUP.
  // A completing edge always has PENABLE=1, so it never coincides with a
  // SETUP read.
  logic do_write;
  assign do_write = complete && pwrite_q && !err_q && !PRESET;

  always_ff @(posedge PCLK) begin
    if (do_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (pstrb_q[i]) mem[idx_q][i*8 +: 8] <= pwdata_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) rdata_q <= '0;
    else if (setup) rdata_q <= err_in ? '0 : mem[idx_in];
  end

  assign PREADY  = (state_reg == S_ACCESS) && (count_reg == 4'd0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = (PREADY && !pwrite_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: drives two apb_slave_mem instances (no wait states /
// non-secure allowed, and 3 wait states / secure-only) from one shared bus,
// with a scoreboard of expected read data, error flag and cycle count.
module tb_apb_slave_mem;

  logic        clk;
  logic        preset;
  logic        psel0, psel3;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  apb_slave_mem #(.WAIT_STATES(0), .SECURE_ONLY(0)) u0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_slave_mem #(.WAIT_STATES(3), .SECURE_ONLY(1)) u3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts #1 after a rising edge and returns #1 after the completing edge,
  // so consecutive calls run back to back.
  task automatic xfer(input bit which, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input logic [31:0] exp_data,
                      input bit exp_err);
    int t0, n;
    bit rdy;
    logic [31:0] got_data;
    logic got_err;
    exp_t e;
    sb.push_back('{exp_data, exp_err, which ? 5 : 2});
    t0 = cyc;
    psel0 = !which; psel3 = which; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0; rdy = 1'b0;
    got_data = '0; got_err = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = which ? pready3 : pready0;
      if (rdy) begin
        got_data = which ? prdata3 : prdata0;
        got_err  = which ? pslverr3 : pslverr0;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    e = sb.pop_front();
    if (!rdy) begin
      chk($sformatf("timeout@%h", addr), 64'(rdy), 64'(1));
      return;
    end
    @(posedge clk); #1;
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%b prot=%b -> rdata=%h err=%0b cycles=%0d",
             which ? 3 : 0, wr ? "WR" : "RD", addr, wdata, strb, prot,
             got_data, got_err, cyc - t0);
    chk($sformatf("rdata@%h", addr), 64'(got_data), 64'(e.data));
    chk($sformatf("err@%h", addr), 64'(got_err), 64'(e.err));
    chk($sformatf("cycles@%h", addr), 64'(cyc - t0), 64'(e.cycles));
  endtask

  initial begin
    preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready0", 64'(pready0), 64'(0));
    chk("rst_pslverr0", 64'(pslverr0), 64'(0));
    chk("rst_prdata0", 64'(prdata0), 64'(0));
    chk("rst_pready3", 64'(pready3), 64'(0));
    chk("rst_pslverr3", 64'(pslverr3), 64'(0));
    chk("rst_prdata3", 64'(prdata3), 64'(0));
    @(posedge clk); #1;
    preset = 1'b0;

    // Zero wait states: basic write/read, byte lanes, errors, PSTRB=0.
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 0);
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 3'b000, 32'h0, 0);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b000, 32'h11BB33DD, 0);
    xfer(0, 1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 0);
    xfer(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 0, 32'h00, 32'h0, 4'hF, 3'b000, 32'hCAFEF00D, 0);
    xfer(0, 0, 32'h13, 32'h0, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 1, 32'h10, 32'h01020304, 4'h0, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 0);
    xfer(0, 1, 32'h3FC, 32'h76543210, 4'hF, 3'b010, 32'h0, 0);
    xfer(0, 0, 32'h3FC, 32'h0, 4'hF, 3'b010, 32'h76543210, 0);
    idle();

    // Three wait states, secure-only: back-to-back reads and protection.
    xfer(1, 1, 32'h30, 32'h0BADC0DE, 4'hF, 3'b000, 32'h0, 0);
    xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b000, 32'h0BADC0DE, 0);
    xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b000, 32'h0BADC0DE, 0);
    xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b010, 32'h0, 1);
    xfer(1, 1, 32'h30, 32'h12121212, 4'hF, 3'b010, 32'h0, 1);
    xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b000, 32'h0BADC0DE, 0);
    xfer(1, 1, 32'h08, 32'h12345678, 4'hF, 3'b000, 32'h0, 0);
    idle();

    // Reset asserted in the 2nd ACCESS cycle of a write.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; preset = 1'b1;
    @(negedge clk);
    chk("rst_mid_pready_before", 64'(pready3), 64'(0));
    @(posedge clk); #1; preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_pready_after", 64'(pready3), 64'(0));
    end
    @(posedge clk); #1;
    xfer(1, 0, 32'h08, 32'h0, 4'hF, 3'b000, 32'h12345678, 0);
    idle();

    // PSEL dropped in the 2nd ACCESS cycle of a write.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_pready", 64'(pready3), 64'(0));
    end
    @(posedge clk); #1;
    xfer(1, 0, 32'h08, 32'h0, 4'hF, 3'b000, 32'h12345678, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
